uart_rx_param: RTL and testbench

//  Parametrised UART receiver for the controller's serial command link.
//  - Configurable data width, parity and stop-bit count; mid-bit sampling from a bit-period counter.
//  - Reports start-glitch rejection, parity and framing errors.
//  - Output word is held under a valid/ready handshake with overrun detection.
//  - Sits between the uart_data pin and the command decoder.

---
 rtl/uart_rx_param_if.sv | 29 ++
 rtl/uart_rx_param.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - received-word handshake bundle between the UART receiver and its consumer
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with mid-bit sampling, error tagging and overrun detect
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 2083,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            uart_data,
    output logic            busy,
    uart_rx_param_if.master rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 sync1_q, sync2_q, prev_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pend_perr_q, pend_perr_d;
    logic                 pend_ferr_q, pend_ferr_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic fall, tick, sample, calc_par, accept;

    assign sample   = sync2_q;
    assign fall     = prev_q & ~sync2_q;
    assign tick     = (cnt_q == '0);
    assign calc_par = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    assign accept   = valid_q & rx.data_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        pend_perr_d = pend_perr_q;
        pend_ferr_d = pend_ferr_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            if (fall) begin
                state_d     = S_START;
                cnt_d       = HALF_LOAD;
                idx_d       = '0;
                pend_perr_d = 1'b0;
                pend_ferr_d = 1'b0;
            end
        end else if (!tick) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = FULL_LOAD;
            case (state_q)
                S_START: state_d = sample ? S_IDLE : S_DATA;
                S_DATA: begin
                    shift_d = {sample, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    pend_perr_d = sample ^ calc_par;
                    state_d     = S_STOP;
                end
                S_STOP: begin
                    pend_ferr_d = pend_ferr_q | ~sample;
                    // Leave mid stop bit so the next start edge is never missed.
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        // A completing frame replaces the held word only if that word is gone or leaving now.
        if (done_q) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                perr_d  = pend_perr_q;
                ferr_d  = pend_ferr_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            pend_perr_q <= 1'b0;
            pend_ferr_q <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            sync1_q     <= uart_data;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            pend_perr_q <= pend_perr_d;
            pend_ferr_q <= pend_ferr_d;
            done_q      <= done_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign rx.data       = data_q;
    assign rx.data_valid = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1, 8E1 and 9N2 instances)
module tb_uart_rx_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic line0 = 1'b1, line1 = 1'b1, line2 = 1'b1;
    logic busy0, busy1, busy2;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();
    uart_rx_param_if #(.DATA_BITS(9)) if2 ();

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_data(line0), .busy(busy0), .rx(if0));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_data(line1), .busy(busy1), .rx(if1));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .uart_data(line2), .busy(busy2), .rx(if2));

    typedef struct {
        int         dut;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    typedef struct {
        int         dut;
        logic [8:0] d;
        logic       flip;
        logic       stop0;
        int         hold;
        logic       pe;
        logic       fe;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        check($sformatf("sb_has_entry_dut%0d", k), 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("word_source_dut%0d", k), k, e.dut);
            check($sformatf("data_dut%0d", k), {23'd0, d}, {23'd0, e.d});
            check($sformatf("parity_err_dut%0d", k), {31'd0, pe}, {31'd0, e.pe});
            check($sformatf("frame_err_dut%0d", k), {31'd0, fe}, {31'd0, e.fe});
        end
    endtask

    always @(negedge clk) begin
        if (if0.data_valid && if0.data_ready) mon(0, {1'b0, if0.data}, if0.parity_err, if0.frame_err);
        if (if1.data_valid && if1.data_ready) mon(1, {1'b0, if1.data}, if1.parity_err, if1.frame_err);
        if (if2.data_valid && if2.data_ready) mon(2, if2.data, if2.parity_err, if2.frame_err);
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int k, input logic v);
        case (k)
            0:       line0 = v;
            1:       line1 = v;
            default: line2 = v;
        endcase
    endtask

    // Frame layout per instance: start, data LSB first, optional even parity, stop bit(s).
    task automatic send_frame(input int k, input logic [8:0] d, input logic flip,
                              input logic stop0, input int hold);
        logic [15:0] fr;
        int          n, nb, ns;
        fr = '0;
        n  = 0;
        nb = (k == 2) ? 9 : 8;
        ns = (k == 2) ? 2 : 1;
        fr[n] = 1'b0; n++;
        for (int i = 0; i < nb; i++) begin
            fr[n] = d[i]; n++;
        end
        if (k == 1) begin
            fr[n] = (^d[7:0]) ^ flip; n++;
        end
        for (int i = 0; i < ns; i++) begin
            fr[n] = ~stop0; n++;
        end
        for (int i = 0; i < n; i++) begin
            drive(k, fr[i]);
            wait_clks(16);
        end
        if (hold > 0) begin
            drive(k, 1'b0);
            wait_clks(hold);
        end
        drive(k, 1'b1);
    endtask

    int c1, first, hi, bc, vseen;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 9'h000, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[1] = '{0, 9'h0FF, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[2] = '{0, 9'h055, 1'b0, 1'b1, 40, 1'b0, 1'b1};
        vecs[3] = '{0, 9'h012, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[4] = '{1, 9'h03C, 1'b1, 1'b0, 0,  1'b1, 1'b0};
        vecs[5] = '{1, 9'h03C, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[6] = '{1, 9'h001, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[7] = '{1, 9'h080, 1'b1, 1'b0, 0,  1'b1, 1'b0};
        vecs[8] = '{2, 9'h1AB, 1'b0, 1'b0, 0,  1'b0, 1'b0};
        vecs[9] = '{2, 9'h155, 1'b0, 1'b1, 0,  1'b0, 1'b1};

        rst_n = 1'b0;
        if0.data_ready = 1'b1;
        if1.data_ready = 1'b1;
        if2.data_ready = 1'b1;
        wait_clks(3);
        check("rst_valid0", {31'd0, if0.data_valid}, 0);
        check("rst_data0", {24'd0, if0.data}, 0);
        check("rst_flags0", {29'd0, if0.parity_err, if0.frame_err, if0.overrun}, 0);
        check("rst_busy", {29'd0, busy0, busy1, busy2}, 0);
        check("rst_valid12", {30'd0, if1.data_valid, if2.data_valid}, 0);
        rst_n = 1'b1;
        wait_clks(4);

        // 0xA5 on 8N1: latency from the start edge and single-cycle valid with ready high.
        c1    = cyc;
        first = -1;
        hi    = 0;
        fork
            begin
                sb.push_back('{0, 9'h0A5, 1'b0, 1'b0});
                send_frame(0, 9'h0A5, 1'b0, 1'b0, 0);
            end
            begin
                for (int i = 0; i < 400 && first < 0; i++) begin
                    @(negedge clk);
                    if (if0.data_valid) first = cyc;
                end
                if (first >= 0) begin
                    hi = 1;
                    for (int i = 0; i < 6; i++) begin
                        @(negedge clk);
                        if (if0.data_valid) hi++;
                    end
                end
            end
        join
        check("latency_a5", first - c1 - 1, 155);
        check("valid_width_a5", hi, 1);
        wait_clks(16);

        for (int i = 0; i < 10; i++) begin
            sb.push_back('{vecs[i].dut, vecs[i].d, vecs[i].pe, vecs[i].fe});
            send_frame(vecs[i].dut, vecs[i].d, vecs[i].flip, vecs[i].stop0, vecs[i].hold);
            wait_clks(24);
        end
        check("sb_drained_table", sb.size(), 0);

        // Short low glitch on an idle line.
        drive(0, 1'b0);
        wait_clks(4);
        drive(0, 1'b1);
        bc    = 0;
        vseen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy0) bc++;
            if (if0.data_valid) vseen++;
        end
        check("glitch_busy_le8", 32'(bc <= 8), 1);
        check("glitch_busy_seen", 32'(bc > 0), 1);
        check("glitch_no_valid", vseen, 0);
        wait_clks(2);

        // Overrun: second frame dropped while the first is held.
        if0.data_ready = 1'b0;
        sb.push_back('{0, 9'h011, 1'b0, 1'b0});
        send_frame(0, 9'h011, 1'b0, 1'b0, 0);
        send_frame(0, 9'h022, 1'b0, 1'b0, 0);
        wait_clks(8);
        check("ovr_valid", {31'd0, if0.data_valid}, 1);
        check("ovr_held_data", {24'd0, if0.data}, 32'h11);
        check("ovr_flag", {31'd0, if0.overrun}, 1);
        if0.data_ready = 1'b1;
        wait_clks(1);
        if0.data_ready = 1'b0;
        check("ovr_accept_valid", {31'd0, if0.data_valid}, 0);
        check("ovr_accept_clear", {31'd0, if0.overrun}, 0);
        wait_clks(8);

        // Accept on the same edge that the second frame completes.
        sb.push_back('{0, 9'h011, 1'b0, 1'b0});
        sb.push_back('{0, 9'h022, 1'b0, 1'b0});
        c1 = cyc;
        fork
            begin
                send_frame(0, 9'h011, 1'b0, 1'b0, 0);
                send_frame(0, 9'h022, 1'b0, 1'b0, 0);
            end
            begin
                for (int i = 0; i < 1000 && cyc != c1 + 315; i++) wait_clks(1);
                if0.data_ready = 1'b1;
                wait_clks(1);
                if0.data_ready = 1'b0;
                check("simul_valid", {31'd0, if0.data_valid}, 1);
                check("simul_data", {24'd0, if0.data}, 32'h22);
                check("simul_no_ovr", {31'd0, if0.overrun}, 0);
            end
        join
        wait_clks(4);
        if0.data_ready = 1'b1;
        wait_clks(1);
        check("simul_drained", {31'd0, if0.data_valid}, 0);
        wait_clks(8);

        // Reset mid-DATA with a word still held.
        if0.data_ready = 1'b0;
        send_frame(0, 9'h033, 1'b0, 1'b0, 0);
        wait_clks(4);
        check("pre_rst_valid", {31'd0, if0.data_valid}, 1);
        drive(0, 1'b0); wait_clks(16);
        drive(0, 1'b0); wait_clks(16);
        drive(0, 1'b1); wait_clks(16);
        drive(0, 1'b1); wait_clks(8);
        check("pre_rst_busy", {31'd0, busy0}, 1);
        rst_n = 1'b0;
        wait_clks(3);
        check("midrst_valid", {31'd0, if0.data_valid}, 0);
        check("midrst_data", {24'd0, if0.data}, 0);
        check("midrst_flags", {29'd0, if0.parity_err, if0.frame_err, if0.overrun}, 0);
        check("midrst_busy", {31'd0, busy0}, 0);
        drive(0, 1'b1);
        rst_n = 1'b1;
        if0.data_ready = 1'b1;
        vseen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if0.data_valid) vseen++;
        end
        check("midrst_no_partial", vseen, 0);
        wait_clks(1);
        sb.push_back('{0, 9'h081, 1'b0, 1'b0});
        send_frame(0, 9'h081, 1'b0, 1'b0, 0);
        wait_clks(24);
        check("sb_drained_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
